// File: rtl/neopixel_pkg.sv
// Shared NeoPixel definitions: pacer FSM encoding, accumulator width and drop
// counter limit, plus the saturating increment used by the drop counter.
package neopixel_pkg;

    localparam int ACC_W = 32;
    localparam logic [7:0] DROP_MAX = 8'hff;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } pacer_state_e;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_pacer_if.sv
// Render handshake between frame_pacer (master) and the LED frame renderer (slave).
// frame_req_out is a level held until the renderer returns frame_ack_in; the
// renderer later returns a one-cycle frame_done_in when the frame is finished.
interface frame_pacer_if;

    logic frame_req_out;
    logic frame_ack_in;
    logic frame_done_in;

    modport master (
        output frame_req_out,
        input  frame_ack_in,
        input  frame_done_in
    );

    modport slave (
        input  frame_req_out,
        output frame_ack_in,
        output frame_done_in
    );

endinterface

// File: rtl/frame_pacer_rate_tick_gen.sv
// Phase-accumulator rate generator: emits a registered one-cycle tick at an
// average of fps_sel_in ticks per CLK_FREQ cycles; fps_sel_in == 0 freezes acc.
module rate_tick_gen
    import neopixel_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] fps_sel_in,
    output logic       tick_out
);

    localparam logic [ACC_W:0] MODULUS = (ACC_W + 1)'(CLK_FREQ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             wrap;

    // One guard bit keeps acc + fps from overflowing before the compare.
    assign sum  = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, fps_sel_in};
    assign wrap = (sum >= MODULUS);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc      <= '0;
            tick_out <= 1'b0;
        end else begin
            tick_out <= wrap;
            acc      <= wrap ? ACC_W'(sum - MODULUS) : sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/frame_pacer.sv
// Frame-rate pacer and render handshake master. Optional busy watchdog is
// built when FRAME_PACER_WATCHDOG_EN is defined; otherwise timeout_out is 0.
module frame_pacer
    import neopixel_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter logic [31:0] WDT_CYCLES = 32'd50_000_000
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic [7:0]    fps_sel_in,
    frame_pacer_if.master rnd,
    output logic          pulse_out,
    output logic          busy_out,
    output logic [7:0]    drop_cnt_out,
    output logic          timeout_out,
    output pacer_state_e  state_out
);

    pacer_state_e state;
    logic         tick;
    logic         req_q;

    rate_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .fps_sel_in (fps_sel_in),
        .tick_out   (tick)
    );

    assign rnd.frame_req_out = req_q;
    assign state_out         = state;

`ifdef FRAME_PACER_WATCHDOG_EN
    logic [31:0] wdt_cnt;
    logic        wdt_expire;

    assign wdt_expire = (wdt_cnt == WDT_CYCLES - 32'd1);
`else
    logic unused_wdt_cycles;

    assign unused_wdt_cycles = ^WDT_CYCLES;
    assign timeout_out       = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state        <= IDLE;
            req_q        <= 1'b0;
            pulse_out    <= 1'b0;
            busy_out     <= 1'b0;
            drop_cnt_out <= '0;
`ifdef FRAME_PACER_WATCHDOG_EN
            timeout_out  <= 1'b0;
            wdt_cnt      <= '0;
`endif
        end else begin
            pulse_out <= 1'b0;
            // A tick while a frame is outstanding is lost, never queued.
            if (tick && (state != IDLE)) begin
                drop_cnt_out <= sat_inc(drop_cnt_out);
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= REQ;
                        req_q    <= 1'b1;
                        busy_out <= 1'b1;
                    end
                end
                REQ: begin
                    if (rnd.frame_ack_in) begin
                        state <= BUSY;
                        req_q <= 1'b0;
`ifdef FRAME_PACER_WATCHDOG_EN
                        wdt_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (rnd.frame_done_in) begin
                        state     <= IDLE;
                        pulse_out <= 1'b1;
                        busy_out  <= 1'b0;
                    end
`ifdef FRAME_PACER_WATCHDOG_EN
                    else if (wdt_expire) begin
                        state       <= IDLE;
                        busy_out    <= 1'b0;
                        timeout_out <= 1'b1;
                    end else begin
                        wdt_cnt <= wdt_cnt + 32'd1;
                    end
`endif
                end
                default: begin
                    state    <= IDLE;
                    req_q    <= 1'b0;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pacer.sv
// Self-checking bench for frame_pacer: tick times come from floor(n*fps/CLK)
// arithmetic, and a frame-in-flight model plus a scripted renderer drives the handshake.
module tb_frame_pacer;
    import neopixel_pkg::*;

    localparam int unsigned CLK_FREQ = 1000;
    localparam int          WDT      = 50;
`ifdef FRAME_PACER_WATCHDOG_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic [7:0]   fps_sel_in = 8'd0;
    logic         pulse_out;
    logic         busy_out;
    logic [7:0]   drop_cnt_out;
    logic         timeout_out;
    pacer_state_e state_out;

    frame_pacer_if rnd_if ();

    frame_pacer #(
        .CLK_FREQ   (CLK_FREQ),
        .WDT_CYCLES (32'(WDT))
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .fps_sel_in   (fps_sel_in),
        .rnd          (rnd_if.master),
        .pulse_out    (pulse_out),
        .busy_out     (busy_out),
        .drop_cnt_out (drop_cnt_out),
        .timeout_out  (timeout_out),
        .state_out    (state_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    int m_fps, edges_n, m_drops, m_age;
    bit m_in_frame, m_req, m_pulse, m_timeout;
    // renderer script
    int ack_max, done_min, done_max, ack_cnt, done_cnt;
    bit withhold, coincide, spurious;
    // observations of the DUT, checked against constants at segment end
    int cyc, pulses_seen, req_rises;
    bit req_prev;
    int rise_t[$];
    int pulse_t[$];

    function automatic bit tick_at(input int n, input int fps);
        if (n <= 0 || fps == 0) return 1'b0;
        return ((n * fps) / int'(CLK_FREQ)) != (((n - 1) * fps) / int'(CLK_FREQ));
    endfunction

    task automatic step();
        bit tk, ack, done;
        pacer_state_e exp_st;
        @(posedge clk_in);
        #1;
        if (rst_in) begin
            edges_n = 0; m_drops = 0; m_age = 0;
            m_in_frame = 0; m_req = 0; m_pulse = 0; m_timeout = 0;
        end else begin
            tk = tick_at(edges_n, m_fps);
            edges_n++;
            m_pulse = 0;
            if (m_in_frame && tk) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
            if (!m_in_frame) begin
                if (tk) begin
                    m_in_frame = 1; m_req = 1;
                    ack_cnt = $urandom_range(ack_max, 0);
                end
            end else if (m_req) begin
                if (rnd_if.frame_ack_in) begin
                    m_req = 0; m_age = 0;
                    done_cnt = $urandom_range(done_max, done_min);
                end
            end else if (rnd_if.frame_done_in) begin
                m_in_frame = 0; m_pulse = 1;
            end else begin
                m_age++;
                if (WDT_EN && m_age == WDT) begin
                    m_in_frame = 0; m_timeout = 1;
                end
            end
        end

        exp_st = !m_in_frame ? IDLE : (m_req ? REQ : BUSY);
        check("req_busy_pulse_tmo", {28'd0, rnd_if.frame_req_out, busy_out, pulse_out, timeout_out},
              {28'd0, m_req, m_in_frame, m_pulse, m_timeout});
        check("drop_cnt", 32'(drop_cnt_out), 32'(m_drops));
        check("state", 32'(state_out), 32'(exp_st));

        cyc++;
        if (rnd_if.frame_req_out && !req_prev) begin req_rises++; rise_t.push_back(cyc); end
        req_prev = rnd_if.frame_req_out;
        if (pulse_out) begin pulses_seen++; pulse_t.push_back(cyc); end

        ack = 0; done = 0;
        if (m_in_frame && m_req) begin
            if (ack_cnt == 0) ack = 1; else ack_cnt--;
        end else if (m_in_frame) begin
            if (coincide) done = tick_at(edges_n, m_fps);
            else if (!withhold) begin
                if (done_cnt == 0) done = 1; else done_cnt--;
            end
        end
        if (spurious) begin
            if (!(m_in_frame && m_req) && $urandom_range(7, 0) == 0) ack = 1;
            if (!(m_in_frame && !m_req) && $urandom_range(7, 0) == 0) done = 1;
        end
        rnd_if.frame_ack_in  = ack;
        rnd_if.frame_done_in = done;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_stats();
        cyc = 0; pulses_seen = 0; req_rises = 0; req_prev = 0;
        rise_t.delete(); pulse_t.delete();
    endtask

    task automatic start_segment(input int fps, input int a_max, input int d_min, input int d_max,
                                 input bit wh, input bit co, input bit sp);
        ack_max = a_max; done_min = d_min; done_max = d_max;
        withhold = wh; coincide = co; spurious = sp;
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
        fps_sel_in = 8'(fps);
        m_fps = fps;
        clear_stats();
    endtask

    initial begin
        rnd_if.frame_ack_in  = 1'b0;
        rnd_if.frame_done_in = 1'b0;
        m_fps = 0; edges_n = 0;
        clear_stats();

        // reset values
        start_segment(10, 0, 5, 5, 0, 0, 0);
        check("reset_outputs", {27'd0, rnd_if.frame_req_out, busy_out, pulse_out, timeout_out, 1'b0},
              32'd0);
        check("reset_drop", 32'(drop_cnt_out), 32'd0);

        // fps=10, instant ack, done 5 later: a pulse every 100 cycles, no drops
        run(1000);
        check("fps10_pulses", 32'(pulses_seen), 32'd9);
        check("fps10_drops", 32'(drop_cnt_out), 32'd0);
        check("fps10_first_pulse", 32'(pulse_t[0]), 32'd108);
        for (int i = 1; i < pulse_t.size(); i++)
            check("fps10_spacing", 32'(pulse_t[i] - pulse_t[i-1]), 32'd100);

        // fps=3: tick intervals 334, 333, 333 and 9 ticks in 3000 cycles
        start_segment(3, 0, 5, 5, 0, 0, 0);
        run(3001);
        check("fps3_ticks", 32'(req_rises), 32'd9);
        for (int i = 0; i < rise_t.size(); i++)
            check("fps3_interval", 32'(rise_t[i] - ((i == 0) ? 1 : rise_t[i-1])),
                  (i % 3 == 0) ? 32'd334 : 32'd333);

        // done withheld ~250 cycles: 2 drops, 1 pulse
        start_segment(10, 0, 250, 250, 0, 0, 0);
        run(390);
        check("hold250_drops", 32'(drop_cnt_out), 32'd2);
        check("hold250_pulses", 32'(pulses_seen), 32'd1);

        // done withheld forever: drop counter saturates
        start_segment(255, 0, 0, 0, 1, 0, 0);
        run(1300);
        check("saturate_drop", 32'(drop_cnt_out), 32'd255);
        check("saturate_pulses", 32'(pulses_seen), 32'd0);

        // tick coincident with done: pulse, 1 drop, no request until next tick
        start_segment(10, 0, 0, 0, 0, 1, 0);
        run(290);
        check("coincide_pulses", 32'(pulses_seen), 32'd1);
        check("coincide_drops", 32'(drop_cnt_out), 32'd1);
        check("coincide_reqs", 32'(req_rises), 32'd1);
        run(20);
        check("coincide_next_req", 32'(req_rises), 32'd2);

        // reset while BUSY aborts the frame; fps=0 then never requests
        start_segment(10, 0, 0, 0, 1, 0, 0);
        run(150);
        check("abort_busy_before", 32'(busy_out), 32'd1);
        rst_in = 1'b1;
        fps_sel_in = 8'd0;
        step();
        check("abort_outputs", {28'd0, rnd_if.frame_req_out, busy_out, pulse_out, timeout_out}, 32'd0);
        check("abort_drop", 32'(drop_cnt_out), 32'd0);
        rst_in = 1'b0;
        m_fps = 0;
        withhold = 0;
        clear_stats();
        run(10000);
        check("fps0_reqs", 32'(req_rises), 32'd0);
        check("fps0_pulses", 32'(pulses_seen), 32'd0);

`ifdef FRAME_PACER_WATCHDOG_EN
        // watchdog: BUSY from edge 102, forced IDLE at edge 152, next tick at 200
        start_segment(10, 0, 0, 0, 1, 0, 0);
        run(160);
        check("wdt_timeout", 32'(timeout_out), 32'd1);
        check("wdt_idle", 32'(busy_out), 32'd0);
        check("wdt_pulses", 32'(pulses_seen), 32'd0);
        run(50);
        check("wdt_new_req", 32'(req_rises), 32'd2);
`endif

        // randomized segments with spurious ack/done outside their states
        for (int s = 0; s < 4; s++) begin
            start_segment($urandom_range(255, 1), $urandom_range(3, 0), 0, $urandom_range(40, 0),
                          0, 0, 1);
            run(2000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
